nmi2ahbl: RTL
=============

Name: nmi2ahbl

Overview:
- NMI-to-AHB-Lite bridge. NMI responder on one side, AHB-Lite initiator on the other; the reverse direction of the existing AHB-Lite-to-NMI path.
- Lets NMI-native cores and DMA masters reach AHB-Lite peripherals and memories.
- Non-pipelined: one outstanding AHB transfer at a time, single transfers only, no bursts.
- Converts NMI byte strobes into AHB hsize/haddr encoding and maps AHB error responses back onto NMI completion.

Parameters:
- HPROT_VAL, 4'b0011: constant driven on hprot_o (data access, privileged).
- ERR_RDATA, 32'h0000_0000: value returned on nmi_rdata_o when an AHB read ends with ERROR.

Ports:
- clk_i  in  1  single clock for both sides.
- rst_i  in  1  synchronous, active-high reset.
- nmi_valid_i  in  1  NMI request valid.
- nmi_ready_o  out  1  NMI completion; one-cycle pulse.
- nmi_addr_i  in  32  byte address.
- nmi_wdata_i  in  32  write data, lane-aligned.
- nmi_wstrb_i  in  4  byte strobes; 0 means read.
- nmi_rdata_o  out  32  read data; valid when nmi_ready_o=1.
- haddr_o  out  32  AHB address.
- htrans_o  out  2  IDLE=2'b00 or NONSEQ=2'b10 only.
- hwrite_o  out  1  AHB write.
- hsize_o  out  3  0=byte, 1=half, 2=word.
- hburst_o  out  3  constant SINGLE (3'b000).
- hprot_o  out  4  constant HPROT_VAL.
- hmastlock_o  out  1  constant 0.
- hwdata_o  out  32  AHB write data.
- hready_i  in  1  AHB transfer done / wait state.
- hresp_i  in  1  AHB response; 1 = ERROR.
- hrdata_i  in  32  AHB read data.
- err_o  out  1  one-cycle pulse when an AHB ERROR is received.
- err_addr_o  out  32  haddr of the last errored beat; held until the next error.

Behaviour:
- Reset: state IDLE. All outputs 0 except hprot_o=HPROT_VAL. htrans_o=IDLE, nmi_ready_o=0, err_o=0, err_addr_o=0.
- FSM states: IDLE, ADDR, DATA, RESP. ADDR and DATA repeat per beat in split mode.
- IDLE:
  - On nmi_valid_i=1, register address, data and strobe, decode the beat, then go to ADDR.
  - Decode rules:
    - wstrb=0: read, hsize=2, haddr[1:0]=00.
    - wstrb=1111: word write.
    - wstrb=0011 or 1100: half write, haddr[1:0]=00 or 10.
    - One-hot wstrb: byte write, haddr[1:0]=index of the set bit.
    - Any other pattern is irregular; see Optional Feature.
- ADDR:
  - htrans_o=NONSEQ; haddr/hwrite/hsize valid.
  - Hold all address-phase signals until hready_i=1, then go to DATA.
- DATA:
  - htrans_o=IDLE; hwdata_o = registered nmi_wdata, full word, lanes unchanged.
  - Wait for hready_i=1.
  - Good response (hresp_i=0): capture hrdata_i for reads.
  - ERROR (hresp_i=1 with hready_i=1, i.e. the 2nd cycle of the AHB error response): pulse err_o, load err_addr_o, set rdata to ERR_RDATA, abort any remaining beats.
  - If more beats remain, go to ADDR; otherwise go to RESP.
- RESP:
  - nmi_ready_o=1 for exactly one cycle with nmi_rdata_o valid, then go to IDLE.
  - nmi_rdata_o holds its value until the next completion.
- Master obligations: must drop nmi_valid_i in the cycle after nmi_ready_o, and must hold the request stable while valid. Request inputs are sampled only in IDLE.
- Latency (zero-wait-state slave): valid at cycle 0 → NONSEQ at cycle 1 → data phase at cycle 2 → nmi_ready_o at cycle 3.
- Each wait state adds 1 cycle.
- hready_i low during ADDR (previous-slave stall) extends ADDR with signals held stable.
- Reset mid-transfer: return to IDLE immediately with htrans_o=IDLE. The AHB slave is reset by the same reset.
- No simultaneous-request case exists: single requester, non-pipelined.

Optional Feature:
- Macro: NMI2AHBL_STRB_SPLIT_EN.
- Defined: an irregular strobe (e.g. 0101, 0111, 1110) is split into sequential byte writes, one per set bit, lowest lane first. Each byte write is its own NONSEQ/data-phase pair. nmi_ready_o is raised once, after the last beat. An ERROR on any beat aborts the remaining beats.
- Undefined: an irregular strobe issues no AHB transfer. The bridge goes IDLE→RESP directly, pulses err_o, and sets err_addr_o = {nmi_addr_i[31:2],2'b00}.

Test Plan:
- Read 0x1000_0004, zero wait, hrdata=0xCAFE_F00D → NONSEQ with hsize=2, hwrite=0 at cycle 1; nmi_ready_o at cycle 3 with rdata 0xCAFE_F00D.
- Write 0x2000_0000, wdata 0x1122_3344, wstrb=0100 → haddr 0x2000_0002, hsize=0, hwdata 0x1122_3344; 3 wait states give nmi_ready_o at cycle 6.
- Write with wstrb=1100 → haddr[1:0]=10, hsize=1; wstrb=1111 → hsize=2, haddr[1:0]=00.
- Read with a two-cycle ERROR response at 0x3000_0010 → err_o pulse, err_addr_o=0x3000_0010, rdata=ERR_RDATA, nmi_ready_o still asserted once.
- wstrb=0101 at 0x4000_0000: with macro → byte writes to 0x4000_0000 then 0x4000_0002, one nmi_ready_o; without macro → no NONSEQ, err_o pulse, err_addr_o=0x4000_0000.
- rst_i asserted during a DATA wait state → next cycle state IDLE, htrans_o=IDLE, nmi_ready_o=0; a new request afterwards completes normally.

Source files
------------

// File: rtl/nmi2ahbl_if.sv
// Bus bundle for the NMI-to-AHB-Lite bridge: NMI request/completion plus AHB-Lite initiator signals.
// The slave modport is the bridge's view; master is the surrounding environment's view.
interface nmi2ahbl_if;
  logic        nmi_valid_i;
  logic        nmi_ready_o;
  logic [31:0] nmi_addr_i;
  logic [31:0] nmi_wdata_i;
  logic [3:0]  nmi_wstrb_i;
  logic [31:0] nmi_rdata_o;
  logic [31:0] haddr_o;
  logic [1:0]  htrans_o;
  logic        hwrite_o;
  logic [2:0]  hsize_o;
  logic [2:0]  hburst_o;
  logic [3:0]  hprot_o;
  logic        hmastlock_o;
  logic [31:0] hwdata_o;
  logic        hready_i;
  logic        hresp_i;
  logic [31:0] hrdata_i;

  modport slave (
    input  nmi_valid_i, nmi_addr_i, nmi_wdata_i, nmi_wstrb_i,
    output nmi_ready_o, nmi_rdata_o,
    output haddr_o, htrans_o, hwrite_o, hsize_o, hburst_o, hprot_o, hmastlock_o, hwdata_o,
    input  hready_i, hresp_i, hrdata_i
  );

  modport master (
    output nmi_valid_i, nmi_addr_i, nmi_wdata_i, nmi_wstrb_i,
    input  nmi_ready_o, nmi_rdata_o,
    input  haddr_o, htrans_o, hwrite_o, hsize_o, hburst_o, hprot_o, hmastlock_o, hwdata_o,
    output hready_i, hresp_i, hrdata_i
  );
endinterface

// File: rtl/nmi2ahbl.sv
// Non-pipelined NMI-responder to AHB-Lite-initiator bridge, one single transfer outstanding.
// NMI2AHBL_STRB_SPLIT_EN: irregular strobes become per-byte writes instead of an immediate error.
module nmi2ahbl #(
  parameter logic [3:0]  HPROT_VAL = 4'b0011,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  nmi2ahbl_if.slave   bus,
  output logic        err_o,
  output logic [31:0] err_addr_o,
  output logic [1:0]  state_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  // NMI handshake: a request is held with nmi_valid_i until nmi_ready_o pulses for one cycle;
  // the request is only sampled in IDLE and the master drops valid the cycle after ready.

  logic [1:0]  state;
  logic [31:0] haddr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [2:0]  hsize_q;
  logic        hwrite_q;
  logic [3:0]  rem_q;
  logic        err_q;
  logic [31:0] err_addr_q;

  logic        dec_write;
  logic        dec_irreg;
  logic [1:0]  dec_lane;
  logic [2:0]  dec_size;
  logic [3:0]  dec_rem;
  logic [1:0]  next_lane;

  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.nmi_addr_i[1:0];

`ifdef NMI2AHBL_STRB_SPLIT_EN
  function automatic logic [1:0] low_lane(input logic [3:0] s);
    if (s[0])      return 2'd0;
    else if (s[1]) return 2'd1;
    else if (s[2]) return 2'd2;
    else           return 2'd3;
  endfunction
  assign next_lane = low_lane(rem_q);
`else
  assign next_lane = haddr_q[1:0];
`endif

  always_comb begin
    dec_write = (bus.nmi_wstrb_i != 4'b0000);
    dec_irreg = 1'b0;
    dec_lane  = 2'd0;
    dec_size  = 3'd2;
    dec_rem   = 4'b0000;
    case (bus.nmi_wstrb_i)
      4'b0000, 4'b1111: ;
      4'b0011: dec_size = 3'd1;
      4'b1100: begin dec_size = 3'd1; dec_lane = 2'd2; end
      4'b0001: begin dec_size = 3'd0; dec_lane = 2'd0; end
      4'b0010: begin dec_size = 3'd0; dec_lane = 2'd1; end
      4'b0100: begin dec_size = 3'd0; dec_lane = 2'd2; end
      4'b1000: begin dec_size = 3'd0; dec_lane = 2'd3; end
      default: begin
`ifdef NMI2AHBL_STRB_SPLIT_EN
        // First byte goes now; rem holds the lanes still to issue (lowest bit cleared).
        dec_size = 3'd0;
        dec_lane = low_lane(bus.nmi_wstrb_i);
        dec_rem  = bus.nmi_wstrb_i & (bus.nmi_wstrb_i - 4'd1);
`else
        dec_irreg = 1'b1;
`endif
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      haddr_q    <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      hsize_q    <= '0;
      hwrite_q   <= 1'b0;
      rem_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.nmi_valid_i) begin
            wdata_q  <= bus.nmi_wdata_i;
            hwrite_q <= dec_write;
            hsize_q  <= dec_size;
            haddr_q  <= {bus.nmi_addr_i[31:2], dec_lane};
            rem_q    <= dec_rem;
            if (dec_irreg) begin
              err_q      <= 1'b1;
              err_addr_q <= {bus.nmi_addr_i[31:2], 2'b00};
              state      <= S_RESP;
            end else begin
              state <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (bus.hready_i) state <= S_DATA;
        end
        S_DATA: begin
          if (bus.hready_i) begin
            if (bus.hresp_i) begin
              err_q      <= 1'b1;
              err_addr_q <= haddr_q;
              rdata_q    <= ERR_RDATA;
              rem_q      <= '0;
              state      <= S_RESP;
            end else begin
              if (!hwrite_q) rdata_q <= bus.hrdata_i;
              if (rem_q != 4'b0000) begin
                haddr_q[1:0] <= next_lane;
                rem_q        <= rem_q & (rem_q - 4'd1);
                state        <= S_ADDR;
              end else begin
                state <= S_RESP;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.nmi_ready_o = (state == S_RESP);
  assign bus.nmi_rdata_o = rdata_q;
  assign bus.htrans_o    = (state == S_ADDR) ? HT_NONSEQ : HT_IDLE;
  assign bus.haddr_o     = haddr_q;
  assign bus.hwrite_o    = hwrite_q;
  assign bus.hsize_o     = hsize_q;
  assign bus.hburst_o    = 3'b000;
  assign bus.hprot_o     = HPROT_VAL;
  assign bus.hmastlock_o = 1'b0;
  assign bus.hwdata_o    = wdata_q;
  assign err_o           = err_q;
  assign err_addr_o      = err_addr_q;
  assign state_o         = state;

endmodule
